hbridge_sequencer: RTL

HBRIDGE_SEQUENCER -- requirements
Module: hbridge_sequencer

---
 rtl/hbridge_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hbridge_sequencer.sv
// H-bridge gate sequencer: IDLE -> BOOT (bootstrap precharge) -> PRESET -> RUN,
// with a latched FAULT on shoot-through requests and a per-output turn-on dead-time stage.
module hbridge_sequencer #(
  parameter int               N_LEG     = 2,
  parameter int               DEADTIME  = 50,
  parameter int               T_BOOT    = 1000,
  parameter int               T_PRESET  = 600,
  parameter logic [N_LEG-1:0] PRESET_HI = N_LEG'(1)
) (
  input  logic             i_clock,
  input  logic             i_RESET,
  input  logic             i_enable,
  input  logic             i_fault_clr,
  input  logic [N_LEG-1:0] i_gate_hi,
  input  logic [N_LEG-1:0] i_gate_lo,
  output logic [N_LEG-1:0] o_gate_hi,
  output logic [N_LEG-1:0] o_gate_lo,
  output logic [2:0]       o_state,
  output logic             o_running,
  output logic             o_fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BOOT   = 3'd1,
    S_PRESET = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam int T_MAX = (T_BOOT > T_PRESET) ? T_BOOT : T_PRESET;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int DW    = $clog2(DEADTIME + 1);
  localparam int NB    = 2 * N_LEG;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             running_q, fault_q;
  logic [N_LEG-1:0] pat_hi, pat_lo;
  logic [NB-1:0]    pat;
  logic [NB-1:0]    out_q;
  logic [DW-1:0]    dt_cnt_q [NB];
  logic             shoot;

  assign shoot = |(i_gate_hi & i_gate_lo);

  // Fault outranks enable loss in RUN so a shoot-through request is always latched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_enable) state_d = S_BOOT;
      S_BOOT: begin
        if (!i_enable)                         state_d = S_IDLE;
        else if (cnt_q == CW'(T_BOOT - 1))     state_d = S_PRESET;
      end
      S_PRESET: begin
        if (!i_enable)                         state_d = S_IDLE;
        else if (cnt_q == CW'(T_PRESET - 1))   state_d = S_RUN;
      end
      S_RUN: begin
        if (shoot)                             state_d = S_FAULT;
        else if (!i_enable)                    state_d = S_IDLE;
      end
      S_FAULT:  if (i_fault_clr && !i_enable) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CW'(1);
  end

  // Pattern follows the next state; a leg requesting both gates is blanked entirely.
  always_comb begin
    pat_hi = '0;
    pat_lo = '0;
    case (state_d)
      S_BOOT:   pat_lo = '1;
      S_PRESET: begin
        pat_hi = PRESET_HI;
        pat_lo = ~PRESET_HI;
      end
      S_RUN: begin
        pat_hi = i_gate_hi & ~i_gate_lo;
        pat_lo = i_gate_lo & ~i_gate_hi;
      end
      default: ;
    endcase
  end

  assign pat = {pat_lo, pat_hi};

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  // Turn-off is immediate; turn-on needs DEADTIME consecutive 1 samples.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      out_q <= '0;
      for (int i = 0; i < NB; i++) dt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (!pat[i]) begin
          dt_cnt_q[i] <= '0;
          out_q[i]    <= 1'b0;
        end else if (dt_cnt_q[i] == DW'(DEADTIME - 1)) begin
          out_q[i]    <= 1'b1;
        end else begin
          dt_cnt_q[i] <= dt_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign o_gate_hi = out_q[N_LEG-1:0];
  assign o_gate_lo = out_q[NB-1:N_LEG];
  assign o_state   = state_q;
  assign o_running = running_q;
  assign o_fault   = fault_q;

endmodule
